// File: rtl/multi_button_debouncer.sv
// Per-channel button debouncer: 2-flop synchroniser, stability counter,
// registered press/release pulses and a one-shot long-press pulse.
module multi_button_debouncer #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 65536,
    parameter int unsigned HOLD_CYCLES   = 12000000,
    parameter bit          ACTIVE_LOW    = 1'b0
) (
    input  logic                i_clock,
    input  logic                i_reset_n,
    input  logic [CHANNELS-1:0] i_buttons,
    output logic [CHANNELS-1:0] o_state,
    output logic [CHANNELS-1:0] o_press_event,
    output logic [CHANNELS-1:0] o_release_event,
    output logic [CHANNELS-1:0] o_long_press_event
);

    localparam int unsigned STABLE_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES + 1);

    localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(STABLE_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_MAX   = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic                sync_meta;
        logic                sync_level;
        logic                state_q;
        logic                press_q;
        logic                release_q;
        logic                long_q;
        logic [STABLE_W-1:0] stable_count;
        logic [HOLD_W-1:0]   hold_count;
        logic                pressed_c;
        logic                differ_c;
        logic                accept_c;

        assign pressed_c = sync_level ^ ACTIVE_LOW;
        assign differ_c  = (pressed_c != state_q);
        // The counter must have reached STABLE_CYCLES and the input still
        // differ one edge later; this yields 2+STABLE_CYCLES edges of latency.
        assign accept_c  = differ_c && (stable_count == STABLE_MAX);

        // Synchroniser idles at the not-pressed raw level.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                sync_meta  <= ACTIVE_LOW;
                sync_level <= ACTIVE_LOW;
            end else begin
                sync_meta  <= i_buttons[ch];
                sync_level <= sync_meta;
            end
        end

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                stable_count <= '0;
            end else if (!differ_c || accept_c) begin
                stable_count <= '0;
            end else begin
                stable_count <= stable_count + STABLE_W'(1);
            end
        end

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                state_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= accept_c && pressed_c;
                release_q <= accept_c && !pressed_c;
                if (accept_c) begin
                    state_q <= pressed_c;
                end
            end
        end

        // A release accepted on the same edge wins over a long-press pulse.
        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                hold_count <= '0;
                long_q     <= 1'b0;
            end else begin
                long_q <= 1'b0;
                if (!state_q || accept_c) begin
                    hold_count <= '0;
                end else if (hold_count != HOLD_MAX) begin
                    hold_count <= hold_count + HOLD_W'(1);
                    long_q     <= (hold_count == HOLD_LAST);
                end
            end
        end

        assign o_state[ch]            = state_q;
        assign o_press_event[ch]      = press_q;
        assign o_release_event[ch]    = release_q;
        assign o_long_press_event[ch] = long_q;
    end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench: one active-high instance driven from a vector table and
// reset sequences, plus an active-low instance for inverted polarity.
module tb_multi_button_debouncer;

    logic       clk;
    logic       rst_n;
    logic [1:0] btn_a;
    logic [1:0] btn_b;
    logic [1:0] state_a, press_a, rel_a, long_a;
    logic [1:0] state_b, press_b, rel_b, long_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] buttons;
        int         reps;
        logic [1:0] state;
        logic [1:0] press;
        logic [1:0] rel;
        logic [1:0] lng;
    } vec_t;

    vec_t vecs[$];

    multi_button_debouncer #(
        .CHANNELS(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b0)
    ) dut_a (
        .i_clock(clk), .i_reset_n(rst_n), .i_buttons(btn_a),
        .o_state(state_a), .o_press_event(press_a),
        .o_release_event(rel_a), .o_long_press_event(long_a)
    );

    multi_button_debouncer #(
        .CHANNELS(2), .STABLE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .i_clock(clk), .i_reset_n(rst_n), .i_buttons(btn_b),
        .o_state(state_b), .o_press_event(press_b),
        .o_release_event(rel_b), .o_long_press_event(long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [1:0] s, input logic [1:0] p,
                         input logic [1:0] r, input logic [1:0] l);
        chk({tag, " a.state"},   state_a, s);
        chk({tag, " a.press"},   press_a, p);
        chk({tag, " a.release"}, rel_a,   r);
        chk({tag, " a.long"},    long_a,  l);
    endtask

    task automatic chk_b(input string tag, input logic [1:0] s, input logic [1:0] p);
        chk({tag, " b.state"},   state_b, s);
        chk({tag, " b.press"},   press_b, p);
        chk({tag, " b.release"}, rel_b,   2'b00);
        chk({tag, " b.long"},    long_b,  2'b00);
    endtask

    task automatic add(input logic [1:0] b, input int n, input logic [1:0] s,
                       input logic [1:0] p, input logic [1:0] r, input logic [1:0] l);
        vecs.push_back('{b, n, s, p, r, l});
    endtask

    initial begin
        rst_n = 1'b0;
        btn_a = 2'b00;
        btn_b = 2'b11;

        // Idle
        add(2'b00, 3,  2'b00, 2'b00, 2'b00, 2'b00);
        // Clean ch0 press, long press at +10, release 6 edges after fall
        add(2'b01, 6,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b01, 1,  2'b01, 2'b01, 2'b00, 2'b00);
        add(2'b01, 9,  2'b01, 2'b00, 2'b00, 2'b00);
        add(2'b01, 1,  2'b01, 2'b00, 2'b00, 2'b01);
        add(2'b01, 10, 2'b01, 2'b00, 2'b00, 2'b00);
        add(2'b00, 6,  2'b01, 2'b00, 2'b00, 2'b00);
        add(2'b00, 1,  2'b00, 2'b00, 2'b01, 2'b00);
        add(2'b00, 4,  2'b00, 2'b00, 2'b00, 2'b00);
        // Bounce 1,0,1,0 every 2 clocks
        add(2'b01, 2,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b00, 2,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b01, 2,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b00, 8,  2'b00, 2'b00, 2'b00, 2'b00);
        // 4-sample pulse: counter reaches 4 but input returns -> rejected
        add(2'b01, 4,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b00, 8,  2'b00, 2'b00, 2'b00, 2'b00);
        // 5-sample pulse: shortest accepted press, then release
        add(2'b01, 5,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b00, 1,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b00, 1,  2'b01, 2'b01, 2'b00, 2'b00);
        add(2'b00, 4,  2'b01, 2'b00, 2'b00, 2'b00);
        add(2'b00, 1,  2'b00, 2'b00, 2'b01, 2'b00);
        add(2'b00, 3,  2'b00, 2'b00, 2'b00, 2'b00);
        // Both channels together
        add(2'b11, 6,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b11, 1,  2'b11, 2'b11, 2'b00, 2'b00);
        add(2'b11, 9,  2'b11, 2'b00, 2'b00, 2'b00);
        add(2'b11, 1,  2'b11, 2'b00, 2'b00, 2'b11);
        add(2'b11, 2,  2'b11, 2'b00, 2'b00, 2'b00);
        add(2'b00, 6,  2'b11, 2'b00, 2'b00, 2'b00);
        add(2'b00, 1,  2'b00, 2'b00, 2'b11, 2'b00);
        add(2'b00, 3,  2'b00, 2'b00, 2'b00, 2'b00);
        // ch1 released exactly as hold reaches HOLD_CYCLES: release only
        add(2'b10, 6,  2'b00, 2'b00, 2'b00, 2'b00);
        add(2'b10, 1,  2'b10, 2'b10, 2'b00, 2'b00);
        add(2'b10, 3,  2'b10, 2'b00, 2'b00, 2'b00);
        add(2'b00, 6,  2'b10, 2'b00, 2'b00, 2'b00);
        add(2'b00, 1,  2'b00, 2'b00, 2'b10, 2'b00);
        add(2'b00, 3,  2'b00, 2'b00, 2'b00, 2'b00);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_a("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        chk_b("reset", 2'b00, 2'b00);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                @(negedge clk) btn_a = vecs[i].buttons;
                @(posedge clk);
                #1;
                chk_a($sformatf("vec%0d.%0d", i, r),
                      vecs[i].state, vecs[i].press, vecs[i].rel, vecs[i].lng);
                chk_b($sformatf("vec%0d.%0d", i, r), 2'b00, 2'b00);
            end
        end

        // Reset 3 edges into a press count, released with ch0 still held
        @(negedge clk) btn_a = 2'b01;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk_a($sformatf("in_reset.%0d", k), 2'b00, 2'b00, 2'b00, 2'b00);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(posedge clk);
            #1;
            chk_a($sformatf("post_reset.%0d", k), (k >= 6) ? 2'b01 : 2'b00,
                  (k == 6) ? 2'b01 : 2'b00, 2'b00, 2'b00);
        end

        // Reset mid-hold clears state asynchronously; no events afterwards
        @(negedge clk);
        rst_n = 1'b0;
        btn_a = 2'b00;
        #1;
        chk("async_reset a.state", state_a, 2'b00);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            chk_a($sformatf("after_abort.%0d", k), 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Active-low instance: ch1 driven low is a press
        @(negedge clk) btn_b = 2'b01;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk_b($sformatf("active_low.%0d", k), (k >= 6) ? 2'b10 : 2'b00,
                  (k == 6) ? 2'b10 : 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
